// File: rtl/bundle_pkg.sv
// ============================================================================
// bundle_pkg: shared state encoding and signed add helpers for bundle_accumulator.
// Rev 1.0
// ============================================================================
`default_nettype none

package bundle_pkg;

    // Widest element the helpers handle; lanes sign-extend into this width.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    function automatic logic signed [MAX_W-1:0] smax(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [MAX_W-1:0] smin(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // Returns {ovf, sum}; sum is the width-bit result sign-extended to MAX_W.
    function automatic logic [MAX_W:0] sat_add(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b,
        input logic                    sat,
        input int                      width
    );
        logic signed [MAX_W-1:0] sum;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        logic                    ovf;
        int                      sh;
        hi  = smax(width);
        lo  = smin(width);
        sh  = MAX_W - width;
        sum = a + b;
        ovf = (sum > hi) || (sum < lo);
        if (ovf) begin
            if (sat) begin
                sum = (sum > hi) ? hi : lo;
            end else begin
                sum = (sum <<< sh) >>> sh;
            end
        end
        return {ovf, sum};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bundle_lane.sv
// ============================================================================
// bundle_lane: one signed accumulator lane with sticky overflow, wrap or saturate.
// Rev 1.0   (optional bin output under BUNDLE_THRESHOLD_EN)
// ============================================================================
`default_nettype none

module bundle_lane #(
    parameter int ELEMENT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     sat,
    input  logic [ELEMENT_WIDTH-1:0] din,
    output logic [ELEMENT_WIDTH-1:0] acc,
`ifdef BUNDLE_THRESHOLD_EN
    output logic                     bin,
`endif
    output logic                     overflow
);
    import bundle_pkg::*;

    localparam int EW = ELEMENT_WIDTH;

    logic [MAX_W-1:0] acc_ext;
    logic [MAX_W-1:0] din_ext;
    logic [MAX_W:0]   add_res;
    logic [EW-1:0]    acc_next;
    logic             ovf_next;
    logic             unused_hi;

    assign acc_ext  = {{(MAX_W-EW){acc[EW-1]}}, acc};
    assign din_ext  = {{(MAX_W-EW){din[EW-1]}}, din};
    assign add_res  = sat_add(acc_ext, din_ext, sat, EW);
    assign acc_next = add_res[EW-1:0];
    assign ovf_next = add_res[MAX_W];
    // Upper bits are only the sign extension of acc_next.
    assign unused_hi = ^add_res[MAX_W-1:EW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            overflow <= 1'b0;
`ifdef BUNDLE_THRESHOLD_EN
            bin      <= 1'b0;
`endif
        end else if (clear) begin
            acc      <= '0;
            overflow <= 1'b0;
`ifdef BUNDLE_THRESHOLD_EN
            bin      <= 1'b0;
`endif
        end else if (enable) begin
            acc      <= acc_next;
            overflow <= overflow | ovf_next;
`ifdef BUNDLE_THRESHOLD_EN
            bin      <= !acc_next[EW-1] && (|acc_next);
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/bundle_accumulator.sv
// ============================================================================
// bundle_accumulator: multi-lane signed hypervector bundling accumulator.
// Rev 1.0   (define BUNDLE_THRESHOLD_EN to add the binarised out_bin port)
// ============================================================================
`default_nettype none

module bundle_accumulator #(
    parameter int ELEMENT_WIDTH = 16,
    parameter int LANES         = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           sat_mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [LANES*ELEMENT_WIDTH-1:0] in_vec,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*ELEMENT_WIDTH-1:0] out_vec,
    output logic [COUNT_WIDTH-1:0]         out_count,
    output logic [LANES-1:0]               overflow,
`ifdef BUNDLE_THRESHOLD_EN
    output logic [LANES-1:0]               out_bin,
`endif
    output logic                           busy
);
    import bundle_pkg::*;

    state_t                 state;
    logic                   mode_sat;
    logic [COUNT_WIDTH-1:0] count;
    logic                   in_active;
    logic                   accept;
    logic                   lane_clear;

    // A start in ACCUM takes priority over the beat presented in that cycle.
    assign in_active  = (state == ACCUM) && !start;
    assign in_ready   = in_active;
    assign accept     = in_active && in_valid;
    assign lane_clear = start && (state != OUTPUT);
    assign out_count  = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mode_sat  <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        mode_sat <= sat_mode;
                        count    <= '0;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        mode_sat <= sat_mode;
                        count    <= '0;
                    end else if (in_valid) begin
                        if (count != '1) begin
                            count <= count + COUNT_WIDTH'(1);
                        end
                        if (in_last) begin
                            state     <= OUTPUT;
                            out_valid <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bundle_lane #(
            .ELEMENT_WIDTH(ELEMENT_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear    (lane_clear),
            .enable   (accept),
            .sat      (mode_sat),
            .din      (in_vec[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]),
            .acc      (out_vec[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]),
`ifdef BUNDLE_THRESHOLD_EN
            .bin      (out_bin[i]),
`endif
            .overflow (overflow[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_bundle_accumulator.sv
// ============================================================================
// tb_bundle_accumulator: directed and randomized checks of bundle_accumulator.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bundle_accumulator;
    localparam int EW = 8;
    localparam int L  = 4;
    localparam int CW = 4;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic          sat_mode  = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b0;
    logic [L*EW-1:0] in_vec  = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [L*EW-1:0] out_vec;
    logic [CW-1:0] out_count;
    logic [L-1:0]  overflow;
`ifdef BUNDLE_THRESHOLD_EN
    logic [L-1:0]  out_bin;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: spec-level bundle state, plain integer lanes.
    int macc[L];
    bit movf[L];
    int mcnt;
    int mst;   // 0 idle, 1 accumulating, 2 result held
    bit msat;

    bundle_accumulator #(
        .ELEMENT_WIDTH(EW),
        .LANES        (L),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sat_mode  (sat_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_count (out_count),
        .overflow  (overflow),
`ifdef BUNDLE_THRESHOLD_EN
        .out_bin   (out_bin),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mclear();
        for (int i = 0; i < L; i++) begin
            macc[i] = 0;
            movf[i] = 1'b0;
        end
        mcnt = 0;
    endtask

    task automatic madd();
        logic [L*EW-1:0] v;
        logic [EW-1:0]   e;
        int              s;
        v = in_vec;
        for (int i = 0; i < L; i++) begin
            e = v[i*EW +: EW];
            s = macc[i] + int'($signed(e));
            if (s > 127 || s < -128) begin
                movf[i] = 1'b1;
                if (msat) s = (s > 127) ? 127 : -128;
                else      s = ((s + 128) & 255) - 128;
            end
            macc[i] = s;
        end
        mcnt = (mcnt < 15) ? mcnt + 1 : 15;
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            mclear();
            mst  = 0;
            msat = 1'b0;
        end else begin
            case (mst)
                0: if (start) begin mclear(); msat = sat_mode; mst = 1; end
                1: begin
                    if (start) begin
                        mclear();
                        msat = sat_mode;
                    end else if (in_valid) begin
                        madd();
                        if (in_last) mst = 2;
                    end
                end
                default: if (out_ready) mst = 0;
            endcase
        end
    endtask

    function automatic logic [L*EW-1:0] mvec();
        logic [L*EW-1:0] v;
        int              a;
        for (int i = 0; i < L; i++) begin
            a = macc[i];
            v[i*EW +: EW] = a[EW-1:0];
        end
        return v;
    endfunction

    function automatic logic [L-1:0] movf_bits();
        logic [L-1:0] b;
        for (int i = 0; i < L; i++) b[i] = movf[i];
        return b;
    endfunction

`ifdef BUNDLE_THRESHOLD_EN
    function automatic logic [L-1:0] mbin();
        logic [L-1:0] b;
        for (int i = 0; i < L; i++) b[i] = (macc[i] > 0);
        return b;
    endfunction
`endif

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, out_valid, (mst == 2));
        chk({tag, ".busy"},      busy,      (mst != 0));
        chk({tag, ".in_ready"},  in_ready,  (mst == 1) && !start);
        chk({tag, ".out_vec"},   out_vec,   mvec());
        chk({tag, ".out_count"}, out_count, mcnt);
        chk({tag, ".overflow"},  overflow,  movf_bits());
`ifdef BUNDLE_THRESHOLD_EN
        chk({tag, ".out_bin"},   out_bin,   mbin());
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic beat(input logic [L*EW-1:0] v, input bit last, input string tag);
        in_valid = 1'b1;
        in_vec   = v;
        in_last  = last;
        step(tag);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start(input bit sm);
        start    = 1'b1;
        sat_mode = sm;
        step("start");
        start    = 1'b0;
        sat_mode = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step(tag);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [L*EW-1:0] rv;
        mclear();
        mst  = 0;
        msat = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.vec_const", out_vec, 32'h0);
        reset_n = 1'b1;
        step("idle");

        // Wrap mode, {1,2,3,4} x3
        do_start(1'b0);
        beat(32'h04030201, 1'b0, "t1b0");
        beat(32'h04030201, 1'b0, "t1b1");
        beat(32'h04030201, 1'b1, "t1b2");
        chk("t1.vec_const",   out_vec,   32'h0C090603);
        chk("t1.count_const", out_count, 4'd3);
        chk("t1.valid_const", out_valid, 1'b1);
        handshake("t1hs");
        chk("t1.hold_vec", out_vec, 32'h0C090603);
        chk("t1.busy_off", busy, 1'b0);

        // Wrap overflow on lane0
        do_start(1'b0);
        beat(32'h00000064, 1'b0, "t2b0");
        beat(32'h00000064, 1'b1, "t2b1");
        chk("t2.vec_const", out_vec,  32'h000000C8);
        chk("t2.ovf_const", overflow, 4'b0001);
        handshake("t2hs");

        // Saturating on lane1, then hold in OUTPUT with pressure on inputs
        do_start(1'b1);
        beat(32'h00009C00, 1'b0, "t3b0");
        beat(32'h00009C00, 1'b0, "t3b1");
        beat(32'h00003200, 1'b1, "t3b2");
        chk("t3.vec_const", out_vec,  32'h0000B200);
        chk("t3.ovf_const", overflow, 4'b0010);
        in_valid = 1'b1;
        in_vec   = 32'h01010101;
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            step("t3hold");
            chk("t3.hold_vec",   out_vec,  32'h0000B200);
            chk("t3.hold_ready", in_ready, 1'b0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        handshake("t3hs");
        chk("t3.busy_off", busy, 1'b0);

        // Restart mid-bundle drops the concurrent beat; then count saturation
        do_start(1'b0);
        beat(32'h01010101, 1'b0, "t4b0");
        beat(32'h01010101, 1'b0, "t4b1");
        start    = 1'b1;
        in_valid = 1'b1;
        in_vec   = 32'h05050505;
        step("t4restart");
        start    = 1'b0;
        in_valid = 1'b0;
        chk("t4.count_zero", out_count, 4'd0);
        chk("t4.vec_zero",   out_vec,   32'h0);
        for (int k = 0; k < 17; k++) beat(32'h01010101, (k == 16), "t4sat");
        chk("t4.count_sat", out_count, 4'd15);
        chk("t4.vec_17",    out_vec,   32'h11111111);
        handshake("t4hs");

        // Randomized bundles against the model
        for (int b = 0; b < 12; b++) begin
            do_start(1'($urandom_range(0, 1)));
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) step("rnd_gap");
                rv = $urandom;
                if ($urandom_range(0, 1) == 1) rv = rv & 32'h3F3F3F3F;
                beat(rv, (k == n - 1), "rnd_beat");
            end
            in_valid = 1'b1;
            in_vec   = $urandom;
            repeat ($urandom_range(0, 3)) step("rnd_wait");
            in_valid = 1'b0;
            handshake("rnd_hs");
        end

        // Asynchronous reset mid-bundle
        do_start(1'b1);
        beat(32'h7F7F7F7F, 1'b0, "t6b0");
        reset_n = 1'b0;
        #2;
        mclear();
        mst  = 0;
        msat = 1'b0;
        check_all("async_rst");
        chk("async_rst.busy_const", busy, 1'b0);
        step("rst_hold");
        reset_n = 1'b1;
        step("post_rst");

`ifdef BUNDLE_THRESHOLD_EN
        do_start(1'b0);
        beat(32'h0001FF01, 1'b0, "t7b0");
        beat(32'h00FFFF01, 1'b0, "t7b1");
        beat(32'h00FF01FF, 1'b1, "t7b2");
        chk("t7.vec_const", out_vec, 32'h00FFFF01);
        chk("t7.bin_const", out_bin, 4'b0001);
        handshake("t7hs");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
